// File: rtl/uart_dbg_pkg.sv
// Shared definitions for the UART debug command sequencer.
// Holds the opcode and response encodings and the sequencer state type.
// Contains no logic of its own.
package uart_dbg_pkg;

  // Command opcodes; the whole 32-bit word is compared.
  localparam logic [31:0] OP_PING   = 32'h0000_0001;
  localparam logic [31:0] OP_PAUSE  = 32'h0000_0002;
  localparam logic [31:0] OP_RESUME = 32'h0000_0003;
  localparam logic [31:0] OP_READ   = 32'h0000_0004;
  localparam logic [31:0] OP_WRITE  = 32'h0000_0005;
  localparam logic [31:0] OP_STATUS = 32'h0000_0006;

  // Response words.
  localparam logic [31:0] RESP_ACK   = 32'h0000_0000;
  localparam logic [31:0] RESP_ERR   = 32'hFFFF_FFFF;
  localparam logic [31:0] PING_MAGIC = 32'h5AFE_0001;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_MEM      = 3'd3,
    ST_SEND     = 3'd4
  } state_t;

endpackage

// File: rtl/uart_dbg_ctrl.sv
// Decodes debug command frames from the UART word stream, runs bus accesses and returns one response word per command.
// Latency: the final rx_ready strobe is followed by tx_valid 2 cycles later for non-memory commands; memory commands add the bus access time.
// Backpressure: the response is held until tx_ready is asserted; rx_ready strobes arriving in MEM or SEND are dropped.
module uart_dbg_ctrl
  import uart_dbg_pkg::*;
#(
  parameter int ARG_TIMEOUT = 100_000_000,
  parameter int MEM_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_ready,
  input  logic [31:0] rx_word,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] tx_word,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        cpu_pause,
  output logic        busy
);

  // One counter serves both timeouts, so it is sized for the larger limit.
  localparam int CNT_MAX = (ARG_TIMEOUT > MEM_TIMEOUT) ? ARG_TIMEOUT : MEM_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] ARG_LIM = CNT_W'(ARG_TIMEOUT);
  localparam logic [CNT_W-1:0] MEM_LIM = CNT_W'(MEM_TIMEOUT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      resp, resp_nxt;
  logic [31:0]      addr_nxt, wdata_nxt;
  logic             we_nxt, pause_nxt, tx_valid_nxt;
  logic             arg_to, mem_to;

  assign arg_to    = (cnt >= ARG_LIM);
  assign mem_to    = (cnt >= MEM_LIM);
  assign mem_req   = (state == ST_MEM);
  assign busy      = (state != ST_IDLE);
  assign tx_word   = resp;

  // State and datapath registers; reset abandons any frame or access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      resp      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_pause <= 1'b0;
      tx_valid  <= 1'b0;
    end else begin
      state     <= state_nxt;
      resp      <= resp_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      cpu_pause <= pause_nxt;
      tx_valid  <= tx_valid_nxt;
    end
  end

  // Shared timeout counter: cleared on any state change and on each argument word, saturates at the larger limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state_nxt != state) ||
                 (rx_ready && ((state == ST_GET_ADDR) || (state == ST_GET_DATA)))) begin
      cnt <= '0;
    end else if (cnt != CNT_SAT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Next-state and next-value decode for the command sequencer.
  always_comb begin
    state_nxt    = state;
    resp_nxt     = resp;
    we_nxt       = mem_we;
    addr_nxt     = mem_addr;
    wdata_nxt    = mem_wdata;
    pause_nxt    = cpu_pause;
    tx_valid_nxt = tx_valid;
    case (state)
      ST_IDLE: begin
        if (rx_ready) begin
          state_nxt = ST_SEND;
          case (rx_word)
            OP_READ, OP_WRITE: begin
              we_nxt    = (rx_word == OP_WRITE);
              state_nxt = ST_GET_ADDR;
            end
            OP_PAUSE: begin
              pause_nxt = 1'b1;
              resp_nxt  = RESP_ACK;
            end
            OP_RESUME: begin
              pause_nxt = 1'b0;
              resp_nxt  = RESP_ACK;
            end
            OP_PING:   resp_nxt = PING_MAGIC;
            OP_STATUS: resp_nxt = {31'b0, cpu_pause};
            default:   resp_nxt = RESP_ERR;
          endcase
        end
      end
      ST_GET_ADDR: begin
        // An argument arriving in the timeout cycle still completes the frame.
        if (rx_ready) begin
          addr_nxt  = rx_word;
          state_nxt = mem_we ? ST_GET_DATA : ST_MEM;
        end else if (arg_to) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_GET_DATA: begin
        if (rx_ready) begin
          wdata_nxt = rx_word;
          state_nxt = ST_MEM;
        end else if (arg_to) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_MEM: begin
        // A late ack in the timeout cycle is still treated as success.
        if (mem_ack) begin
          resp_nxt  = mem_we ? RESP_ACK : mem_rdata;
          state_nxt = ST_SEND;
        end else if (mem_to) begin
          resp_nxt  = RESP_ERR;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        // tx_valid rises one cycle after entering SEND and falls on handshake.
        if (!tx_valid) begin
          tx_valid_nxt = 1'b1;
        end else if (tx_ready) begin
          tx_valid_nxt = 1'b0;
          state_nxt    = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_dbg_ctrl.sv
// Directed bench for the UART debug command sequencer.
// Drives command frames and a hand-driven bus responder; compares against hand-computed values.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
module tb_uart_dbg_ctrl;

  localparam int ARG_TO = 50;
  localparam int MEM_TO = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_ready = 1'b0;
  logic [31:0] rx_word = '0;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] tx_word;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        cpu_pause;
  logic        busy;

  int checks = 0;
  int errors = 0;

  uart_dbg_ctrl #(.ARG_TIMEOUT(ARG_TO), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .rst(rst),
    .rx_ready(rx_ready), .rx_word(rx_word),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_word(tx_word),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .cpu_pause(cpu_pause), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle rx_ready strobe carrying w.
  task automatic send_word(input logic [31:0] w);
    rx_ready = 1'b1;
    rx_word  = w;
    step();
    rx_ready = 1'b0;
    rx_word  = '0;
  endtask

  // Wait (bounded) for a response, check it, accept it and confirm return to idle.
  task automatic expect_resp(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    while (tx_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_vld"}, tx_valid, 1);
    chk({tag, "_word"}, tx_word, exp);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk({tag, "_idle"}, {tx_valid, busy}, 0);
  endtask

  initial begin
    #100_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw_tx;

    // Reset state
    repeat (3) step();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_pause", cpu_pause, 0);
    chk("rst_tx_word", tx_word, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // PING: tx_valid two cycles after the strobe, held under backpressure
    send_word(32'h0000_0001);
    chk("ping_c1_vld", tx_valid, 0);
    chk("ping_c1_busy", busy, 1);
    step();
    chk("ping_c2_vld", tx_valid, 1);
    chk("ping_word", tx_word, 32'h5AFE_0001);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ping_hold_vld", tx_valid, 1);
      chk("ping_hold_word", tx_word, 32'h5AFE_0001);
    end
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("ping_done_vld", tx_valid, 0);
    chk("ping_done_busy", busy, 0);

    // WRITE 0xDEADBEEF to 0x1000, ack after 3 cycles
    send_word(32'h0000_0005);
    send_word(32'h0000_1000);
    send_word(32'hDEAD_BEEF);
    chk("wr_req", mem_req, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 32'h0000_1000);
    chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    repeat (3) step();
    chk("wr_req_held", mem_req, 1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("wr_req_drop", mem_req, 0);
    expect_resp("wr_resp", 32'h0000_0000);

    // READ 0x1000 returns bus data
    send_word(32'h0000_0004);
    send_word(32'h0000_1000);
    chk("rd_req", mem_req, 1);
    chk("rd_we", mem_we, 0);
    chk("rd_addr", mem_addr, 32'h0000_1000);
    mem_rdata = 32'hDEAD_BEEF;
    mem_ack   = 1'b1;
    step();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    expect_resp("rd_resp", 32'hDEAD_BEEF);

    // Pause control and status readback
    send_word(32'h0000_0002);
    chk("pause_lvl", cpu_pause, 1);
    expect_resp("pause_resp", 32'h0000_0000);
    send_word(32'h0000_0006);
    expect_resp("status_paused", 32'h0000_0001);
    send_word(32'h0000_0003);
    chk("resume_lvl", cpu_pause, 0);
    expect_resp("resume_resp", 32'h0000_0000);
    send_word(32'h0000_0006);
    expect_resp("status_run", 32'h0000_0000);

    // Unknown opcode
    send_word(32'h1234_5678);
    expect_resp("unk_resp", 32'hFFFF_FFFF);

    // Bus timeout: request held while the counter runs 0..MEM_TO, then ERR
    send_word(32'h0000_0004);
    send_word(32'h0000_2000);
    n = 0;
    while (mem_req === 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("memto_len", n, MEM_TO + 1);
    expect_resp("memto_resp", 32'hFFFF_FFFF);

    // Argument timeout: silent return to idle after counter reaches ARG_TO
    send_word(32'h0000_0004);
    n = 0;
    saw_tx = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      step();
      n++;
      if (tx_valid === 1'b1) saw_tx = 1'b1;
    end
    chk("argto_len", n, ARG_TO + 1);
    chk("argto_silent", {31'b0, saw_tx}, 0);
    send_word(32'h0000_0001);
    expect_resp("argto_ping", 32'h5AFE_0001);

    // Argument arriving in the timeout cycle wins
    send_word(32'h0000_0004);
    repeat (ARG_TO) step();
    chk("argedge_busy", busy, 1);
    send_word(32'h0000_3000);
    chk("argedge_req", mem_req, 1);
    chk("argedge_addr", mem_addr, 32'h0000_3000);
    mem_rdata = 32'hCAFE_F00D;
    mem_ack   = 1'b1;
    step();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    expect_resp("argedge_resp", 32'hCAFE_F00D);

    // Reset mid-access: everything dropped, no response, pause cleared
    send_word(32'h0000_0002);
    expect_resp("pause2_resp", 32'h0000_0000);
    send_word(32'h0000_0005);
    send_word(32'h0000_4000);
    send_word(32'h0000_0011);
    chk("rstmem_req_pre", mem_req, 1);
    rst = 1'b1;
    step();
    chk("rstmem_req", mem_req, 0);
    chk("rstmem_busy", busy, 0);
    chk("rstmem_pause", cpu_pause, 0);
    rst = 1'b0;
    saw_tx = 1'b0;
    repeat (5) begin
      step();
      if (tx_valid === 1'b1) saw_tx = 1'b1;
    end
    chk("rstmem_silent", {31'b0, saw_tx}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_dbg_ctrl.md
Name: uart_dbg_ctrl

Overview:
- Command sequencer for the UART debug link. Consumes 32-bit big-endian words from the word receiver (one-shot rx_ready/rx_word) and decodes command/argument frames.
- Drives a single-master memory/MMIO bus and the core pause line. Returns one 32-bit response word per command through the word transmitter (valid/ready).
- Sits between the UART word receiver, the UART word transmitter and the target core's debug bus mux.

Parameters:
- ARG_TIMEOUT, 100_000_000, max clocks between command word and each following argument word before the frame is abandoned.
- MEM_TIMEOUT, 1024, max clocks waiting for mem_ack before the access is aborted.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rx_ready  in  1  one-cycle strobe: rx_word valid
- rx_word  in  32  received word
- tx_valid  out  1  response word valid; held until tx_ready
- tx_ready  in  1  transmitter accepts tx_word this cycle when tx_valid=1
- tx_word  out  32  response word
- mem_req  out  1  bus request; held until mem_ack or timeout
- mem_we  out  1  1=write, 0=read; stable while mem_req
- mem_addr  out  32  byte address; stable while mem_req
- mem_wdata  out  32  write data; stable while mem_req
- mem_rdata  in  32  read data, valid in the mem_ack cycle
- mem_ack  in  1  one-cycle completion strobe
- cpu_pause  out  1  level; 1 = core halted
- busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset: outputs tx_valid=0, tx_word=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_pause=0, busy=0. All counters are 0 and state is IDLE. Reset mid-frame or mid-access drops everything immediately; no response is sent.
- Opcodes (full 32-bit compare): PING=0x0000_0001, PAUSE=0x0000_0002, RESUME=0x0000_0003, READ=0x0000_0004, WRITE=0x0000_0005, STATUS=0x0000_0006.
- Responses: ACK=0x0000_0000 (PAUSE, RESUME, WRITE ok); PING returns 0x5AFE_0001; READ returns mem_rdata; STATUS returns {31'b0, cpu_pause}; ERR=0xFFFF_FFFF for an unknown opcode or a bus timeout.
- IDLE:
  - rx_ready with READ/WRITE -> GET_ADDR.
  - PAUSE sets cpu_pause=1, RESUME clears it; both apply in the cycle after the strobe, then -> SEND.
  - PING, STATUS and unknown opcodes -> SEND.
- GET_ADDR: rx_ready latches mem_addr. Next state is GET_DATA (WRITE) or MEM (READ).
- GET_DATA: rx_ready latches mem_wdata, then -> MEM.
- Argument timeout: the counter clears on entry to GET_ADDR/GET_DATA and on every rx_ready. When the counter reaches ARG_TIMEOUT, return to IDLE silently with no response. rx_ready in the same cycle as the timeout wins.
- MEM:
  - mem_req=1 from the first cycle in MEM.
  - mem_ack -> capture mem_rdata (reads), drop mem_req next cycle, -> SEND.
  - Counter reaching MEM_TIMEOUT -> drop mem_req, respond ERR. mem_ack in the same cycle as the timeout counts as success.
- SEND: tx_valid=1 with tx_word stable. On tx_valid&&tx_ready, clear tx_valid next cycle and go to IDLE. Latency from the final rx_ready to tx_valid is 2 cycles for non-memory commands.
- rx_ready arriving in MEM or SEND is ignored (dropped). No command queuing.
- Reads and writes are legal regardless of cpu_pause; no auto-pause.
- Counters are wide enough to hold the larger of ARG_TIMEOUT and MEM_TIMEOUT, and saturate at the limit rather than wrapping.

Decomposition:
- Package uart_dbg_pkg:
  - opcode constants and response constants (ACK, ERR, PING_MAGIC)
  - state enum: IDLE, GET_ADDR, GET_DATA, MEM, SEND
- No sub-module. A single counter is shared between the argument timeout and the bus timeout, cleared on every state change.

Test Plan:
- Reset state: after rst, busy=0, tx_valid=0, mem_req=0, cpu_pause=0.
- PING: rx 0x00000001 -> tx_valid 2 cycles later, tx_word=0x5AFE0001. Hold tx_ready=0 for 5 cycles -> tx_word stays stable; tx_ready=1 -> idle next cycle.
- WRITE then READ:
  - WRITE, addr 0x00001000, data 0xDEADBEEF -> mem_req with mem_we=1, addr/wdata as given. Ack after 3 cycles -> response 0x00000000.
  - READ 0x00001000 with mem_rdata=0xDEADBEEF -> response 0xDEADBEEF.
- Pause control: PAUSE -> cpu_pause=1, response 0 -> STATUS returns 0x00000001 -> RESUME -> STATUS returns 0x00000000.
- Error paths:
  - Opcode 0x12345678 -> ERR.
  - READ with mem_ack never asserted -> mem_req drops at MEM_TIMEOUT and the response is 0xFFFFFFFF.
- Argument timeout: READ followed by no argument for ARG_TIMEOUT (set to 50) -> returns to IDLE with no tx_valid. A PING immediately after is answered normally. rst asserted mid-MEM -> mem_req=0 next cycle and no response.
